// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Returns {remainder, quotient} 33 cycles after accepting a request.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    DivFree,
    DivByZero,
    DivOn,
    DivEnd
  } state_t;

  state_t      state;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic [5:0]  cnt;
  logic        signed_div;
  logic        op1_sign;
  logic        op2_sign;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] trial;
  logic [31:0] quot;
  logic [31:0] rem;

  // Operand magnitudes, trial subtraction and final sign correction
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    if (signed_div_i && opdata1_i[31]) op1_abs = -opdata1_i;
    if (signed_div_i && opdata2_i[31]) op2_abs = -opdata2_i;
    trial = {1'b0, dividend[63:32]} - {1'b0, divisor};
    quot = dividend[31:0];
    rem  = dividend[64:33];
    if (signed_div && (op1_sign ^ op2_sign)) quot = -dividend[31:0];
    if (signed_div && op1_sign) rem = -dividend[64:33];
  end

  // Control FSM and datapath; annul overrides every transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DivFree;
      cnt        <= 6'd0;
      ready_o    <= 1'b0;
      result_o   <= 64'd0;
      dividend   <= 65'd0;
      divisor    <= 32'd0;
      signed_div <= 1'b0;
      op1_sign   <= 1'b0;
      op2_sign   <= 1'b0;
    end else if (annul_i) begin
      state    <= DivFree;
      cnt      <= 6'd0;
      ready_o  <= 1'b0;
      result_o <= 64'd0;
    end else begin
      unique case (state)
        DivFree: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i) begin
            if (opdata2_i == 32'd0) begin
              state <= DivByZero;
            end else begin
              signed_div <= signed_div_i;
              op1_sign   <= opdata1_i[31];
              op2_sign   <= opdata2_i[31];
              dividend   <= {32'd0, op1_abs, 1'b0};
              divisor    <= op2_abs;
              cnt        <= 6'd0;
              state      <= DivOn;
            end
          end
        end
        DivByZero: begin
          dividend <= 65'd0;
          result_o <= 64'd0;
          ready_o  <= 1'b1;
          state    <= DivEnd;
        end
        DivOn: begin
          if (cnt != 6'd32) begin
            if (trial[32]) begin
              dividend <= {dividend[63:0], 1'b0};
            end else begin
              dividend <= {trial[31:0], dividend[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {rem, quot};
            ready_o  <= 1'b1;
            cnt      <= 6'd0;
            state    <= DivEnd;
          end
        end
        DivEnd: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= 64'd0;
            state    <= DivFree;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Testbench for div: vector table, scoreboard queue,
// plus annul and asynchronous reset sequences.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
  } vec_t;

  vec_t        vt[12];
  logic [63:0] sb[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called right after the accepting edge; returns at a negedge.
  task automatic wait_ready(input int exp_lat, input string name);
    int lat;
    logic [63:0] exp;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ready_o && lat < 60);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 64'hDEAD;
    check({name, " result"}, result_o, exp);
  endtask

  task automatic drop_check(input string name);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, " drop"}, {result_o[62:0], ready_o}, 64'd0);
  endtask

  task automatic run(input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] r,
                     input string name);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb.push_back(r);
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
    wait_ready((b == 32'd0) ? 1 : 33, name);
    drop_check(name);
  endtask

  initial begin
    int hi;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;

    vt[0]  = '{1'b0, 32'd100,       32'd7,       {32'd2, 32'd14}};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,       {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vt[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}};
    vt[3]  = '{1'b1, 32'd5,         32'd0,       64'd0};
    vt[4]  = '{1'b0, 32'd5,         32'd0,       64'd0};
    vt[5]  = '{1'b0, 32'd9,         32'd3,       {32'd0, 32'd3}};
    vt[6]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, {32'd0, 32'h80000000}};
    vt[7]  = '{1'b0, 32'hFFFFFFFF,  32'd1,       {32'd0, 32'hFFFFFFFF}};
    vt[8]  = '{1'b0, 32'd3,         32'hFFFFFFFF, {32'd3, 32'd0}};
    vt[9]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}};
    vt[10] = '{1'b1, 32'd100,       32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}};
    vt[11] = '{1'b0, 32'd20,        32'd6,       {32'd2, 32'd3}};

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    #1;
    check("reset state", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run(vt[i].s, vt[i].a, vt[i].b, vt[i].r, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      s = i[0];
      a = $urandom;
      b = (i < 4) ? $urandom_range(1, 1000) : $urandom;
      if (b == 32'd0) b = 32'd1;
      if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
      run(s, a, b, {r, q}, $sformatf("rnd%0d", i));
    end

    // annul mid-division
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) hi++;
    end
    check("annul no ready", 64'(hi), 64'd0);
    check("annul result", result_o, 64'd0);
    run(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, "after annul");

    // async reset mid-division with start held
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid rst clear", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back({32'd0, 32'd10});
    @(posedge clk);
    wait_ready(33, "post rst");
    #2 rst = 1'b1;
    #1;
    check("end rst clear", {result_o[62:0], ready_o}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
